mux_n_pipe: RTL
===============

MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each data input and of the output.
REQ-002 SHALL have parameter N_IN, default 4, legal range 2..16: number of selectable inputs.
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(N_IN)): select width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_data, input, N_IN*DATA_W: flattened inputs; input k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port in_sel, input, SEL_W: index of the input to forward.
REQ-008 SHALL have port in_valid, input, 1: in_data and in_sel are valid this cycle.
REQ-009 SHALL have port in_ready, output, 1: the block can accept a beat this cycle.
REQ-010 SHALL have port flush, input, 1: synchronous discard of all held beats.
REQ-011 SHALL have port out_data, output, DATA_W: the selected and registered data.
REQ-012 SHALL have port out_sel_err, output, 1: the current output beat came from an out-of-range select.
REQ-013 SHALL have port out_valid, output, 1: out_data and out_sel_err are valid.
REQ-014 SHALL have port out_ready, input, 1: the consumer accepts the output beat.
REQ-015 SHALL have port err_cnt, output, 8: saturating count of accepted out-of-range selects.

Function
REQ-016 SHALL define accept = in_valid && in_ready and output transfer = out_valid && out_ready.
REQ-017 SHALL, on accept, capture input in_sel when in_sel < N_IN; otherwise it SHALL capture input 0 with the sel_err flag set.
REQ-018 SHALL present an accepted beat on out_data and out_valid exactly 1 cycle after accept when the output register is empty or transferring; latency SHALL be 1 cycle minimum.
REQ-019 SHALL keep out_data and out_sel_err stable while out_valid=1 and out_ready=0.
REQ-020 SHALL deliver beats in acceptance order with no loss or duplication.
REQ-021 SHALL increment err_cnt by 1 on each accept with an out-of-range select, and saturate at 255.
REQ-022 SHALL, on flush=1, clear out_valid and any held beat at the next edge; a beat offered in the flush cycle SHALL be dropped and SHALL NOT update err_cnt; err_cnt itself is not cleared by flush.
REQ-023 SHALL, on simultaneous transfer and accept, replace the output beat with no idle cycle, sustaining 1 beat per cycle.
REQ-024 SHALL have out_data values that depend only on captured state; there is no combinational path from in_data to out_data.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set out_valid=0, out_sel_err=0, out_data=0, err_cnt=0, and clear the skid entry.
REQ-026 SHALL give rst priority over flush and accept; a beat offered during reset SHALL be dropped.
REQ-027 SHALL hold in_ready=0 while rst=1.

Configuration
REQ-028 SHALL support the macro MUX_N_PIPE_SKID_EN.
REQ-029 SHALL, when MUX_N_PIPE_SKID_EN is defined, include a 1-entry skid buffer and drive in_ready = !skid_valid directly from a register.
  - When out_ready=0 and out_valid=1, one further beat SHALL be accepted into the skid entry.
  - The skid entry SHALL move to the output register on the next transfer.
REQ-030 SHALL, when MUX_N_PIPE_SKID_EN is not defined, have no skid entry and use in_ready = !out_valid || out_ready, which is combinational from out_ready.

Verification
REQ-031 SHALL cover basic select: N_IN=4, in_data={D,C,B,A}=16'h000D..000A, in_sel=2, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=16'h000C, out_sel_err=0.
REQ-032 SHALL cover an out-of-range select: N_IN=3, in_sel=3 -> out_data equals input 0, out_sel_err=1, err_cnt goes 0->1.
REQ-033 SHALL cover backpressure:
  - Stream of 5 beats with out_ready=0 for 3 cycles mid-stream.
  - Output SHALL be all 5 beats in order, with out_data stable while stalled.
  - With SKID_EN, exactly 2 beats SHALL be held before in_ready=0.
REQ-034 SHALL cover flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, the offered beat is never output, and err_cnt is unchanged.
REQ-035 SHALL cover saturation: 300 accepted out-of-range selects -> err_cnt=255 and holds there.
REQ-036 SHALL cover reset mid-stream: rst=1 for 1 cycle during a stalled transfer -> all outputs 0 next cycle, in_ready=0 during reset, and the first beat after reset appears with 1-cycle latency.

Source files
------------

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: registered N-input select with valid/ready handshake and error count.
// Define MUX_N_PIPE_SKID_EN to add a 1-entry skid buffer with registered in_ready.
module mux_n_pipe #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 4,
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              err_cnt
);

    localparam logic [31:0] N_LIM = 32'(N_IN);

    logic              sel_ok;
    logic [DATA_W-1:0] sel_data;
    logic              take;

    // Out-of-range selects fall back to input 0 and are tagged.
    always_comb begin
        sel_ok   = (32'(in_sel) < N_LIM);
        sel_data = in_data[DATA_W-1:0];
        for (int k = 0; k < N_IN; k++) begin
            if (sel_ok && (in_sel == SEL_W'(k))) begin
                sel_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign take = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (take && !sel_ok && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef MUX_N_PIPE_SKID_EN

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_err;

    assign in_ready = !skid_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel_err <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_valid && !out_ready) begin
            // Output stalled: park one more beat in the skid entry.
            if (take) begin
                skid_valid <= 1'b1;
                skid_data  <= sel_data;
                skid_err   <= !sel_ok;
            end
        end else if (skid_valid) begin
            out_valid   <= 1'b1;
            out_data    <= skid_data;
            out_sel_err <= skid_err;
            skid_valid  <= 1'b0;
        end else if (take) begin
            out_valid   <= 1'b1;
            out_data    <= sel_data;
            out_sel_err <= !sel_ok;
        end else begin
            out_valid <= 1'b0;
        end
    end

`else

    assign in_ready = (!out_valid || out_ready) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel_err <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid   <= 1'b1;
            out_data    <= sel_data;
            out_sel_err <= !sel_ok;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule
